systolic_mxn_stream: RTL
========================

Name: systolic_mxn_stream

Overview:
- Parametrised successor to the team's square int8 systolic matrix multiplier.
- Computes C[ROWS x COLS] = A[ROWS x K] * B[K x COLS] on an output-stationary PE grid with rectangular geometry and configurable operand width.
- Fetches operands from local SRAM through a read port, applies internal input skew, and streams results out over a valid/ready interface with backpressure, row-wise or column-wise.
- Sits between the operand buffers and the writeback DMA.

Parameters:
- ROWS, 4, PE grid rows (A rows); >=2
- COLS, 4, PE grid columns (B columns); >=2
- DW, 8, signed operand width
- KW, 8, width of k_param; max K = 2^KW-1
- OUT_W, 24, signed result width on out_data
- AW, 13, read address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; accepted only in IDLE
- abort  in  1  synchronous abort, any state
- k_param  in  KW  inner dimension K, sampled on accepted start
- out_mode  in  1  0=row drain, 1=column drain; sampled on accepted start
- rd_en  out  1  operand read strobe (active high)
- rd_addr  out  AW  operand address
- row_in  in  ROWS*DW  A column k, lane i = A[i][k]; valid 1 cycle after rd_en
- col_in  in  COLS*DW  B row k, lane j = B[k][j]; valid 1 cycle after rd_en
- busy  out  1  high in any state except IDLE
- calc_done  out  1  1-cycle pulse on COMPUTE->OUT
- out_valid  out  1  result beat valid
- out_ready  in  1  sink ready
- out_data  out  max(ROWS,COLS)*OUT_W  result vector; unused upper lanes zero
- out_idx  out  8  row index (mode 0) or column index (mode 1) of the beat
- out_last  out  1  final beat of the matrix

Behaviour:
- Reset: FSM=IDLE; all accumulators, skew registers and counters 0; every output 0.
- FSM states: IDLE, COMPUTE, OUT.
- IDLE->COMPUTE on start && !abort:
  - latch K and mode;
  - clear all accumulators and skew registers;
  - cnt=0.
- COMPUTE:
  - rd_en=1, rd_addr=cnt for cnt 0..K-1, else rd_en=0, rd_addr=0.
  - Lane i of row_in is delayed i cycles before entering PE[i][0]; lane j of col_in is delayed j cycles before entering PE[0][j].
  - Operands propagate one PE per cycle; zeros are injected outside the valid window.
  - Each PE does acc += a*b every COMPUTE cycle.
  - COMPUTE lasts exactly K+ROWS+COLS cycles (cnt 0..K+ROWS+COLS-1), then goes to OUT with calc_done pulsed for 1 cycle.
- Accumulator width ACC_W = 2*DW+KW, full signed precision; no overflow is possible internally.
- OUT, mode 0:
  - ROWS beats, beat r: lane j = C[r][j].
  - out_last=1 on r=ROWS-1.
- OUT, mode 1:
  - COLS beats, beat c: lane i = C[i][c].
  - out_last=1 on c=COLS-1.
- OUT handshake:
  - out_valid=1 throughout OUT.
  - A beat transfers on out_valid&&out_ready.
  - out_data, out_idx and out_last are held stable while out_ready=0.
  - After the last beat transfers, the next state is IDLE and out_valid=0 in that cycle.
- Narrowing ACC_W->OUT_W: keep the OUT_W LSBs (two's-complement wrap) unless the optional feature is enabled.
- Boundary conditions:
  - K=0: COMPUTE lasts ROWS+COLS cycles with no reads; all results 0.
  - start while busy: ignored; latched K and mode unchanged.
  - abort in any state: next cycle FSM=IDLE, out_valid=0, rd_en=0, no calc_done; accumulators are not guaranteed.
  - abort and start in the same cycle: abort wins.
  - rst_n low mid-operation: immediate return to reset values.

Optional Feature:
- Macro SYSTOLIC_SAT_EN.
- Defined: narrowing saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: truncation/wrap as above.
- Internal ACC_W precision is identical in both builds.

Test Plan:
- Identity test (4x4, K=4, mode 0): A=I, B=values 1..16 row-major, out_ready=1.
  - busy high exactly 4+4+4+4 cycles.
  - 4 beats equal to the B rows; out_last on idx 3.
- K=1, mode 1: all A=-128, all B=-128 -> 4 beats, every lane 16384; out_idx 0..3.
- Backpressure: out_ready pattern 1,0,0,1,0,1,1 -> beats transfer only when ready=1; data and out_idx stable while stalled; exactly 4 transfers.
- OUT_W=16, K=255, all operands 127:
  - without SYSTOLIC_SAT_EN, every lane = -15873;
  - with the macro, every lane = 32767.
- K=0 -> no rd_en pulses; all-zero results.
- Control corners:
  - start during COMPUTE ignored.
  - abort at cnt=3 -> IDLE next cycle, no calc_done; a following start with K=2 gives correct results.
  - rst_n asserted mid-OUT -> all outputs 0.

Source files
------------

// File: rtl/systolic_mxn_stream_if.sv
// Bundle for systolic_mxn_stream: control, operand read port and result stream.
// master = the array side, slave = the controller/SRAM/sink side.
interface systolic_mxn_stream_if #(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned KW    = 8,
  parameter int unsigned OUT_W = 24,
  parameter int unsigned AW    = 13
);
  localparam int unsigned LANES = (ROWS > COLS) ? ROWS : COLS;

  logic                   start;
  logic                   abort;
  logic [KW-1:0]          k_param;
  logic                   out_mode;
  logic                   rd_en;
  logic [AW-1:0]          rd_addr;
  logic [ROWS*DW-1:0]     row_in;
  logic [COLS*DW-1:0]     col_in;
  logic                   busy;
  logic                   calc_done;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] out_data;
  logic [7:0]             out_idx;
  logic                   out_last;

  modport master (
    input  start, abort, k_param, out_mode, row_in, col_in, out_ready,
    output rd_en, rd_addr, busy, calc_done, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    output start, abort, k_param, out_mode, row_in, col_in, out_ready,
    input  rd_en, rd_addr, busy, calc_done, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/systolic_mxn_stream.sv
// Output-stationary ROWS x COLS int systolic matmul with skewed SRAM feed and streamed drain.
// Define SYSTOLIC_SAT_EN to saturate results to OUT_W instead of wrapping.
module systolic_mxn_stream #(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned KW    = 8,
  parameter int unsigned OUT_W = 24,
  parameter int unsigned AW    = 13
) (
  input logic                 clk,
  input logic                 rst_n,
  systolic_mxn_stream_if.master bus
);

  localparam int unsigned LANES = (ROWS > COLS) ? ROWS : COLS;
  localparam int unsigned ACC_W = 2 * DW + KW;
  localparam int unsigned CNT_W = $clog2((1 << KW) + ROWS + COLS);

`ifdef SYSTOLIC_SAT_EN
  localparam int unsigned NW = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic signed [NW-1:0] SAT_MAX = NW'({1'b0, {(OUT_W - 1){1'b1}}});
  localparam logic signed [NW-1:0] SAT_MIN = ~SAT_MAX;
`endif

  typedef enum logic [1:0] {StIdle, StCompute, StOut} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       beat_q, beat_d;
  logic [KW-1:0]    k_q, k_d;
  logic             mode_q, mode_d;
  logic             rd_vld_q;
  logic             calc_done_q;
  logic             clear, compute, cnt_last, beat_last, rd_en;

  logic signed [DW-1:0]    a_lane [ROWS];
  logic signed [DW-1:0]    b_lane [COLS];
  logic signed [DW-1:0]    a_skew [ROWS];
  logic signed [DW-1:0]    b_skew [COLS];
  logic signed [DW-1:0]    a_op   [ROWS][COLS];
  logic signed [DW-1:0]    b_op   [ROWS][COLS];
  logic signed [DW-1:0]    a_q    [ROWS][COLS-1];
  logic signed [DW-1:0]    b_q    [ROWS-1][COLS];
  logic signed [ACC_W-1:0] acc_q  [ROWS][COLS];

  function automatic logic signed [2*DW-1:0] mul(input logic signed [DW-1:0] x,
                                                 input logic signed [DW-1:0] y);
    return (2 * DW)'(x) * (2 * DW)'(y);
  endfunction

  function automatic logic [OUT_W-1:0] narrow(input logic signed [ACC_W-1:0] v);
`ifdef SYSTOLIC_SAT_EN
    logic signed [NW-1:0] w;
    w = NW'(v);
    if (w > SAT_MAX) begin
      w = SAT_MAX;
    end else if (w < SAT_MIN) begin
      w = SAT_MIN;
    end
    return OUT_W'(w);
`else
    return OUT_W'(v);
`endif
  endfunction

  assign compute   = (state_q == StCompute);
  assign cnt_last  = (cnt_q == (CNT_W'(k_q) + CNT_W'(ROWS + COLS - 1)));
  assign beat_last = (beat_q == (mode_q ? 8'(COLS - 1) : 8'(ROWS - 1)));
  assign rd_en     = compute && (cnt_q < CNT_W'(k_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    k_d     = k_q;
    mode_d  = mode_q;
    clear   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          state_d = StCompute;
          k_d     = bus.k_param;
          mode_d  = bus.out_mode;
          cnt_d   = '0;
          clear   = 1'b1;
        end
      end
      StCompute: begin
        if (cnt_last) begin
          state_d = StOut;
          beat_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          if (beat_last) begin
            state_d = StIdle;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (bus.abort) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      beat_q      <= '0;
      k_q         <= '0;
      mode_q      <= 1'b0;
      rd_vld_q    <= 1'b0;
      calc_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      k_q         <= k_d;
      mode_q      <= mode_d;
      rd_vld_q    <= rd_en && !bus.abort;
      calc_done_q <= compute && cnt_last && !bus.abort;
    end
  end

  // SRAM data is only meaningful the cycle after a read; zeros otherwise.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      a_lane[i] = rd_vld_q ? bus.row_in[i*DW +: DW] : '0;
    end
    for (int j = 0; j < COLS; j++) begin
      b_lane[j] = rd_vld_q ? bus.col_in[j*DW +: DW] : '0;
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
    if (i == 0) begin : g_direct
      assign a_skew[i] = a_lane[i];
    end else begin : g_delay
      logic signed [DW-1:0] sr_q [i];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sr_q <= '{default: '0};
        end else if (clear) begin
          sr_q <= '{default: '0};
        end else if (compute) begin
          sr_q[0] <= a_lane[i];
          for (int d = 1; d < i; d++) begin
            sr_q[d] <= sr_q[d-1];
          end
        end
      end
      assign a_skew[i] = sr_q[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_b_skew
    if (j == 0) begin : g_direct
      assign b_skew[j] = b_lane[j];
    end else begin : g_delay
      logic signed [DW-1:0] sr_q [j];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sr_q <= '{default: '0};
        end else if (clear) begin
          sr_q <= '{default: '0};
        end else if (compute) begin
          sr_q[0] <= b_lane[j];
          for (int d = 1; d < j; d++) begin
            sr_q[d] <= sr_q[d-1];
          end
        end
      end
      assign b_skew[j] = sr_q[j-1];
    end
  end

  // a flows east along a row, b flows south along a column, one PE per cycle.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      a_op[i][0] = a_skew[i];
      for (int j = 1; j < COLS; j++) begin
        a_op[i][j] = a_q[i][j-1];
      end
    end
    for (int j = 0; j < COLS; j++) begin
      b_op[0][j] = b_skew[j];
      for (int i = 1; i < ROWS; i++) begin
        b_op[i][j] = b_q[i-1][j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '{default: '0};
      b_q   <= '{default: '0};
      acc_q <= '{default: '0};
    end else if (clear) begin
      a_q   <= '{default: '0};
      b_q   <= '{default: '0};
      acc_q <= '{default: '0};
    end else if (compute) begin
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS - 1; j++) begin
          a_q[i][j] <= a_op[i][j];
        end
      end
      for (int i = 0; i < ROWS - 1; i++) begin
        for (int j = 0; j < COLS; j++) begin
          b_q[i][j] <= b_op[i][j];
        end
      end
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          acc_q[i][j] <= acc_q[i][j] + ACC_W'(mul(a_op[i][j], b_op[i][j]));
        end
      end
    end
  end

  always_comb begin
    bus.busy      = (state_q != StIdle);
    bus.rd_en     = rd_en;
    bus.rd_addr   = rd_en ? AW'(cnt_q) : '0;
    bus.calc_done = calc_done_q;
    bus.out_valid = (state_q == StOut);
    bus.out_idx   = (state_q == StOut) ? beat_q : 8'd0;
    bus.out_last  = (state_q == StOut) && beat_last;
    bus.out_data  = '0;
    if (state_q == StOut) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (!mode_q && (beat_q == 8'(r))) begin
            bus.out_data[c*OUT_W +: OUT_W] = narrow(acc_q[r][c]);
          end
          if (mode_q && (beat_q == 8'(c))) begin
            bus.out_data[r*OUT_W +: OUT_W] = narrow(acc_q[r][c]);
          end
        end
      end
    end
  end

endmodule
